// File: rtl/sc_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : sc_ifetch
// Brief    : PC register, instruction fetch handshake and next-PC selection,
//            with a fetch-timeout halt.
// Revision : 1.0 - initial release
// ============================================================================
module sc_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clock,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic [1:0]  pcsource,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        fetch_err
);

  localparam int c_CW = $clog2(TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_TLAST = c_CW'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_EXEC  = 2'd2;
  localparam logic [1:0] c_HALT  = 2'd3;

  logic [1:0]      r_state;
  logic [31:0]     r_pc;
  logic [31:0]     r_inst;
  logic            r_fetch_err;
  logic [c_CW-1:0] r_tcnt;

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;
  logic        w_unused;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
  // Low two bits of the jr target are dropped, so they never reach the PC.
  assign w_unused = &{1'b0, rs_data[1:0]};

  always_comb begin
    w_next_pc = w_pc4;
    case (pcsource)
      2'b00:   w_next_pc = w_pc4;
      2'b01:   w_next_pc = w_pc4 + w_br_off;
      2'b10:   w_next_pc = {rs_data[31:2], 2'b00};
      default: w_next_pc = {w_pc4[31:28], r_inst[25:0], 2'b00};
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= c_IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= 32'd0;
      r_fetch_err <= 1'b0;
      r_tcnt      <= '0;
    end else begin
      case (r_state)
        c_IDLE: r_state <= c_FETCH;
        c_FETCH: begin
          // Ack wins even on the last allowed wait cycle.
          if (imem_ack) begin
            r_inst  <= imem_rdata;
            r_tcnt  <= '0;
            r_state <= c_EXEC;
          end else if (r_tcnt == c_TLAST) begin
            r_tcnt      <= r_tcnt + 1'b1;
            r_fetch_err <= 1'b1;
            r_state     <= c_HALT;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        c_EXEC: begin
          if (!stall) begin
            r_pc    <= w_next_pc;
            r_state <= c_FETCH;
          end
        end
        default: r_state <= c_HALT;
      endcase
    end
  end

  assign imem_req   = (r_state == c_FETCH);
  assign inst_valid = (r_state == c_EXEC);
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign pc4        = w_pc4;
  assign inst       = r_inst;
  assign fetch_err  = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_sc_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_ifetch
// Brief    : Directed vector bench for sc_ifetch (TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_ifetch;

  logic        clock;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [1:0]  pcsource;
  logic [31:0] rs_data;
  logic        stall;
  logic        fetch_err;

  int n_tests;
  int n_fail;

  sc_ifetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc4        (pc4),
    .pcsource   (pcsource),
    .rs_data    (rs_data),
    .stall      (stall),
    .fetch_err  (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic [1:0]  ps;
    logic [31:0] rs;
    logic        stl;
    logic        e_req;
    logic        e_val;
    logic        e_err;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(logic ack, logic [31:0] rdata, logic [1:0] ps,
                              logic [31:0] rs, logic stl, logic e_req,
                              logic e_val, logic e_err, logic [31:0] e_pc,
                              logic [31:0] e_inst);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ps = ps; v.rs = rs; v.stl = stl;
    v.e_req = e_req; v.e_val = e_val; v.e_err = e_err;
    v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic check(string name, logic e_req, logic e_val, logic e_err,
                       logic [31:0] e_pc, logic [31:0] e_inst);
    logic [31:0] e_pc4;
    e_pc4 = e_pc + 32'd4;
    n_tests++;
    if (imem_req !== e_req || inst_valid !== e_val || fetch_err !== e_err ||
        pc !== e_pc || imem_addr !== e_pc || pc4 !== e_pc4 || inst !== e_inst) begin
      n_fail++;
      $display("FAIL %s: got req=%b val=%b err=%b pc=%h addr=%h pc4=%h inst=%h; want req=%b val=%b err=%b pc=%h pc4=%h inst=%h",
               name, imem_req, inst_valid, fetch_err, pc, imem_addr, pc4, inst,
               e_req, e_val, e_err, e_pc, e_pc4, e_inst);
    end
  endtask

  task automatic drive(logic ack, logic [31:0] rdata, logic [1:0] ps,
                       logic [31:0] rs, logic stl);
    imem_ack = ack; imem_rdata = rdata; pcsource = ps; rs_data = rs; stall = stl;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //           ack rdata         ps    rs            stl req val err pc            inst
    vecs[0]  = mk(1, 32'hAAAA0000, 2'd0, 32'h0,        0,  0,  0,  0, 32'h00000000, 32'h00000000);
    vecs[1]  = mk(1, 32'h11111111, 2'd0, 32'h0,        0,  1,  0,  0, 32'h00000000, 32'h00000000);
    vecs[2]  = mk(0, 32'h0,        2'd0, 32'h0,        0,  0,  1,  0, 32'h00000000, 32'h11111111);
    vecs[3]  = mk(1, 32'h22222222, 2'd0, 32'h0,        0,  1,  0,  0, 32'h00000004, 32'h11111111);
    vecs[4]  = mk(0, 32'h0,        2'd0, 32'h0,        0,  0,  1,  0, 32'h00000004, 32'h22222222);
    vecs[5]  = mk(1, 32'h33333333, 2'd0, 32'h0,        0,  1,  0,  0, 32'h00000008, 32'h22222222);
    vecs[6]  = mk(0, 32'h0,        2'd0, 32'h0,        0,  0,  1,  0, 32'h00000008, 32'h33333333);
    vecs[7]  = mk(1, 32'h44444444, 2'd0, 32'h0,        0,  1,  0,  0, 32'h0000000C, 32'h33333333);
    vecs[8]  = mk(0, 32'h0,        2'd0, 32'h0,        0,  0,  1,  0, 32'h0000000C, 32'h44444444);
    vecs[9]  = mk(1, 32'h1000FFFE, 2'd0, 32'h0,        0,  1,  0,  0, 32'h00000010, 32'h44444444);
    vecs[10] = mk(0, 32'h0,        2'd1, 32'h0,        0,  0,  1,  0, 32'h00000010, 32'h1000FFFE);
    vecs[11] = mk(1, 32'h00000008, 2'd0, 32'h0,        0,  1,  0,  0, 32'h0000000C, 32'h1000FFFE);
    vecs[12] = mk(0, 32'h0,        2'd2, 32'h00400023, 0,  0,  1,  0, 32'h0000000C, 32'h00000008);
    vecs[13] = mk(1, 32'h00000009, 2'd0, 32'h0,        0,  1,  0,  0, 32'h00400020, 32'h00000008);
    vecs[14] = mk(0, 32'h0,        2'd2, 32'h10000000, 0,  0,  1,  0, 32'h00400020, 32'h00000009);
    vecs[15] = mk(1, 32'h08000040, 2'd0, 32'h0,        0,  1,  0,  0, 32'h10000000, 32'h00000009);
    vecs[16] = mk(0, 32'h0,        2'd3, 32'h0,        0,  0,  1,  0, 32'h10000000, 32'h08000040);
    vecs[17] = mk(0, 32'hBBBBBBBB, 2'd0, 32'h0,        0,  1,  0,  0, 32'h10000100, 32'h08000040);
    vecs[18] = mk(0, 32'hBBBBBBBB, 2'd0, 32'h0,        0,  1,  0,  0, 32'h10000100, 32'h08000040);
    vecs[19] = mk(0, 32'hBBBBBBBB, 2'd0, 32'h0,        0,  1,  0,  0, 32'h10000100, 32'h08000040);
    vecs[20] = mk(1, 32'h55555555, 2'd0, 32'h0,        0,  1,  0,  0, 32'h10000100, 32'h08000040);
    vecs[21] = mk(0, 32'h0,        2'd1, 32'h0,        1,  0,  1,  0, 32'h10000100, 32'h55555555);
    vecs[22] = mk(1, 32'hDEADBEEF, 2'd3, 32'h0,        1,  0,  1,  0, 32'h10000100, 32'h55555555);
    vecs[23] = mk(0, 32'h0,        2'd2, 32'h12345678, 1,  0,  1,  0, 32'h10000100, 32'h55555555);
    vecs[24] = mk(0, 32'h0,        2'd2, 32'hFFFFFFFE, 0,  0,  1,  0, 32'h10000100, 32'h55555555);
    vecs[25] = mk(1, 32'h66666666, 2'd0, 32'h0,        0,  1,  0,  0, 32'hFFFFFFFC, 32'h55555555);
    vecs[26] = mk(0, 32'h0,        2'd0, 32'h0,        0,  0,  1,  0, 32'hFFFFFFFC, 32'h66666666);
    vecs[27] = mk(0, 32'h0,        2'd0, 32'h0,        0,  1,  0,  0, 32'h00000000, 32'h66666666);
    vecs[28] = mk(0, 32'h0,        2'd0, 32'h0,        0,  1,  0,  0, 32'h00000000, 32'h66666666);
    vecs[29] = mk(0, 32'h0,        2'd0, 32'h0,        0,  1,  0,  0, 32'h00000000, 32'h66666666);
    vecs[30] = mk(0, 32'h0,        2'd0, 32'h0,        0,  1,  0,  0, 32'h00000000, 32'h66666666);
    vecs[31] = mk(1, 32'h77777777, 2'd0, 32'h0,        0,  0,  0,  1, 32'h00000000, 32'h66666666);
    vecs[32] = mk(1, 32'h88888888, 2'd3, 32'h0,        0,  0,  0,  1, 32'h00000000, 32'h66666666);

    // Reset state
    resetn = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 32'h0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < 33; i++) begin
      drive(vecs[i].ack, vecs[i].rdata, vecs[i].ps, vecs[i].rs, vecs[i].stl);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_val, vecs[i].e_err,
            vecs[i].e_pc, vecs[i].e_inst);
      @(posedge clock);
      #1;
    end

    // HALT holds over many cycles despite acks
    drive(1'b1, 32'h99999999, 2'd2, 32'h00000040, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    check("halt_held", 1'b0, 1'b0, 1'b1, 32'h0, 32'h66666666);

    // Asynchronous reset clears HALT without an edge
    #2 resetn = 1'b0;
    #1;
    check("halt_async_clear", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset mid-EXEC: no PC update, inst back to nop
    drive(1'b1, 32'hCAFEF00D, 2'd2, 32'h00000100, 1'b0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    check("restart_fetch", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    check("restart_exec", 1'b0, 1'b1, 1'b0, 32'h0, 32'hCAFEF00D);
    #2 resetn = 1'b0;
    #1;
    check("exec_abort", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    check("exec_abort_hold", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
